// File: rtl/prio_req_scheduler.sv
// Rising-edge request capture with per-line masking and fixed-priority selection.
// The lowest-numbered eligible line is granted on a registered valid/ready port.
module prio_req_scheduler #(
    parameter int REQ_W = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REQ_W-1:0] req_in,
    input  logic [REQ_W-1:0] mask,
    input  logic             clr_all,
    output logic             grant_valid,
    input  logic             grant_ready,
    output logic [IDX_W-1:0] grant_idx,
    output logic [REQ_W-1:0] pending,
    output logic             overflow
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]       state;
    logic [REQ_W-1:0] req_d;
    logic [REQ_W-1:0] rise;
    logic [REQ_W-1:0] clr_vec;
    logic [REQ_W-1:0] elig;
    logic [REQ_W-1:0] pending_nxt;
    logic             overflow_nxt;
    logic             accept;
    logic [IDX_W-1:0] sel_idx;

    assign grant_valid = (state == HOLD);
    assign accept      = grant_valid & grant_ready;
    assign rise        = req_in & ~req_d;
    assign elig        = pending & ~mask;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        clr_vec = '0;
        if (accept)
            clr_vec[grant_idx] = 1'b1;
        // A rise wins over a same-cycle acceptance, and is not an overflow then.
        pending_nxt  = (pending & ~clr_vec) | rise;
        overflow_nxt = overflow | (|(rise & pending & ~clr_vec));
    end

    // Scan downward so the lowest-numbered eligible line is the last one written.
    always_comb begin
        sel_idx = '0;
        for (int i = REQ_W - 1; i >= 0; i--) begin
            if (elig[i])
                sel_idx = i[IDX_W-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        req_d <= req_in;
        if (reset) begin
            pending   <= '0;
            overflow  <= 1'b0;
            state     <= IDLE;
            grant_idx <= '0;
        end else if (clr_all) begin
            pending  <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
        end else begin
            pending  <= pending_nxt;
            overflow <= overflow_nxt;
            case (state)
                IDLE: begin
                    if (elig != '0) begin
                        grant_idx <= sel_idx;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (grant_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prio_req_scheduler.sv
// Directed bench for prio_req_scheduler: hand-computed expectations checked
// one time unit after each rising edge.
module tb_prio_req_scheduler;

    logic       clk;
    logic       reset;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic       clr_all;
    logic       grant_valid;
    logic       grant_ready;
    logic [2:0] grant_idx;
    logic [7:0] pending;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    prio_req_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .req_in      (req_in),
        .mask        (mask),
        .clr_all     (clr_all),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .grant_idx   (grant_idx),
        .pending     (pending),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1; req_in = 8'hFF; mask = 8'h00; clr_all = 1'b0; grant_ready = 1'b0;
        tick();
        tick();
        check("rst_pending", pending, 8'h00);
        check("rst_valid", grant_valid, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_idx", grant_idx, 3'd0);

        // Lines held high through reset never become requests.
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("held_pending", pending, 8'h00);
            check("held_valid", grant_valid, 1'b0);
        end

        // Two simultaneous rises served in priority order with the IDLE bubble.
        req_in = 8'h00;
        tick();
        req_in = 8'h24; grant_ready = 1'b1;
        tick();
        check("two_pending", pending, 8'h24);
        check("two_valid_lat", grant_valid, 1'b0);
        tick();
        check("two_valid_a", grant_valid, 1'b1);
        check("two_idx_a", grant_idx, 3'd2);
        tick();
        check("two_bubble", grant_valid, 1'b0);
        check("two_pending_b", pending, 8'h20);
        tick();
        check("two_valid_b", grant_valid, 1'b1);
        check("two_idx_b", grant_idx, 3'd5);
        tick();
        check("two_done", pending, 8'h00);
        check("two_done_valid", grant_valid, 1'b0);
        grant_ready = 1'b0; req_in = 8'h00;
        tick();

        // Masked line skipped, then all-masked stall, then unmasked.
        mask = 8'h01; grant_ready = 1'b1; req_in = 8'h09;
        tick();
        check("mask_pending", pending, 8'h09);
        req_in = 8'h00;
        tick();
        check("mask_idx3", grant_idx, 3'd3);
        check("mask_valid", grant_valid, 1'b1);
        tick();
        check("mask_pending_b", pending, 8'h01);
        tick();
        check("all_masked_valid", grant_valid, 1'b0);
        check("all_masked_pending", pending, 8'h01);
        mask = 8'h00;
        tick();
        check("unmask_idx0", grant_idx, 3'd0);
        check("unmask_valid", grant_valid, 1'b1);
        tick();
        check("unmask_done", pending, 8'h00);
        grant_ready = 1'b0;

        // Grant held stable while stalled, despite a higher-priority arrival.
        req_in = 8'h10;
        tick();
        req_in = 8'h00;
        tick();
        check("hold_idx4", grant_idx, 3'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", grant_valid, 1'b1);
            check("stall_idx", grant_idx, 3'd4);
        end
        req_in = 8'h02;
        tick();
        check("hp_arrival_idx", grant_idx, 3'd4);
        check("hp_arrival_pending", pending, 8'h12);
        req_in = 8'h00;
        tick();
        check("hp_still_idx", grant_idx, 3'd4);
        grant_ready = 1'b1;
        tick();
        check("hold_accept_pending", pending, 8'h02);
        check("hold_accept_valid", grant_valid, 1'b0);
        tick();
        check("next_idx1", grant_idx, 3'd1);
        tick();
        check("hold_done", pending, 8'h00);
        grant_ready = 1'b0;

        // Overflow on a masked pending line, then clr_all during a committed grant.
        mask = 8'h40; req_in = 8'h40;
        tick();
        check("ovf_pre", overflow, 1'b0);
        req_in = 8'h00;
        tick();
        req_in = 8'h44;
        tick();
        check("ovf_set", overflow, 1'b1);
        check("ovf_pending", pending, 8'h44);
        tick();
        check("ovf_grant_idx", grant_idx, 3'd2);
        check("ovf_grant_valid", grant_valid, 1'b1);
        clr_all = 1'b1; grant_ready = 1'b1; req_in = 8'h46;
        tick();
        check("clr_pending", pending, 8'h00);
        check("clr_overflow", overflow, 1'b0);
        check("clr_valid", grant_valid, 1'b0);
        check("clr_idx_kept", grant_idx, 3'd2);
        clr_all = 1'b0; grant_ready = 1'b0; mask = 8'h00;
        tick();
        check("clr_rise_dropped", pending, 8'h00);
        check("clr_after_valid", grant_valid, 1'b0);
        req_in = 8'h00;
        tick();

        // Acceptance and a new rise on the same line in one cycle.
        req_in = 8'h08;
        tick();
        req_in = 8'h00;
        tick();
        check("same_idx3", grant_idx, 3'd3);
        grant_ready = 1'b1; req_in = 8'h08;
        tick();
        check("same_pending_kept", pending, 8'h08);
        check("same_no_overflow", overflow, 1'b0);
        check("same_bubble", grant_valid, 1'b0);
        tick();
        check("same_regrant_valid", grant_valid, 1'b1);
        check("same_regrant_idx", grant_idx, 3'd3);
        tick();
        check("same_done", pending, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_req_scheduler.md
Name: prio_req_scheduler

Overview:
- Sequential front end for the 8-input priority encoder.
- Captures rising edges on 8 request lines into a pending register and applies a per-line mask.
- Selects the lowest-numbered pending, unmasked line (bit 0 = highest priority, same ordering as the encoder).
- Presents the selected index on a registered valid/ready grant port and clears that line's pending bit when the grant is accepted.

Parameters:
- REQ_W, 8, number of request lines; fixed at 8 for this revision.
- IDX_W, 3, grant index width; must equal clog2(REQ_W).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_in  input  8  raw request lines; a request is a 0->1 transition between consecutive clk samples.
- mask  input  8  1 = line masked: it can still become pending but is never selected.
- clr_all  input  1  synchronous flush of pending, overflow and the grant.
- grant_valid  output  1  grant_idx holds a committed grant.
- grant_ready  input  1  consumer accepts the grant when grant_valid & grant_ready.
- grant_idx  output  3  index of the granted line.
- pending  output  8  current pending register, registered.
- overflow  output  1  sticky: a rising edge arrived on a line that was already pending.

Behaviour:
- Reset, reset high at an edge:
  - pending=0, overflow=0, grant_valid=0, grant_idx=0, state=IDLE.
  - req_d <= req_in, so lines held high through reset produce no request.
- Edge detect:
  - rise = req_in & ~req_d, evaluated every non-reset cycle.
  - req_d <= req_in every cycle, including during clr_all.
- Pending update, per bit i each cycle:
  - A bit is set by rise[i].
  - A bit is cleared by an accepted grant with grant_idx==i.
  - Set beats clear when both happen in the same cycle, so the bit stays pending.
- Overflow:
  - Set when rise[i] & pending[i] and bit i is not being cleared that cycle.
  - Cleared only by reset or clr_all.
- Eligible vector: elig = pending & ~mask, using the registered pending and the current mask.
- State machine, two states:
  - IDLE: grant_valid=0. If elig!=0, then at the edge grant_idx <= lowest set bit of elig, grant_valid <= 1, go to HOLD. Otherwise stay in IDLE.
  - HOLD: grant_valid=1 and grant_idx is held stable until acceptance.
  - HOLD ignores mask changes and new higher-priority arrivals; the grant is committed.
  - On grant_valid & grant_ready: clear pending[grant_idx], grant_valid <= 0, go to IDLE.
- Latency:
  - Edge seen at clk edge t → pending bit visible after t → grant_valid high after edge t+1.
  - Minimum 2 cycles between accepted grants; the IDLE bubble is mandatory.
- clr_all, at a non-reset edge:
  - pending=0, overflow=0, grant_valid=0, state=IDLE.
  - Rises in the same cycle are dropped.
  - grant_idx keeps its previous value.
  - clr_all beats a simultaneous acceptance; no separate clear is needed.
- Priority order: reset > clr_all > normal operation.
- All lines masked with pending!=0: stay in IDLE and keep pending unchanged.
- grant_ready high while grant_valid=0: no effect.
- Outputs are registered only; there is no combinational path from inputs to outputs.

Test Plan:
- Reset with req_in=8'hFF held high, then released and held → pending stays 8'h00, grant_valid stays 0 for 10 cycles.
- req_in 0→8'b0010_0100 at edge t, grant_ready=1 → grant_valid after t+1 with idx=2, then idx=5 two cycles later, then pending=0.
- pending=8'b0000_1001, mask=8'h01, grant_ready=1 → first idx=3. After mask=0, next idx=0.
- grant_valid with idx=4, grant_ready=0 for 5 cycles, then a rise on line 1 → idx stays 4 until accepted. Next grant idx=1.
- Line 6 pending and not granted, second rise on line 6 → overflow=1 and pending[6]=1. Later clr_all → overflow=0, pending=0, grant_valid=0.
- Accept idx=3 in the same cycle as a new rise on line 3 → pending[3] stays 1, overflow stays 0, next grant idx=3.
